// File: rtl/buffer_pkg.sv
// Shared sizing for the buffer pointer controller: default address width,
// depth derivation and pointer width (address plus one wrap bit).
package buffer_pkg;

  localparam int BUFFER_WIDTH_DEF = 2;

  function automatic int buf_depth(input int bw);
    return 1 << bw;
  endfunction

  function automatic int ptr_width(input int bw);
    return bw + 1;
  endfunction

  localparam int DEPTH_DEF = buf_depth(BUFFER_WIDTH_DEF);
  localparam int PTR_W_DEF = ptr_width(BUFFER_WIDTH_DEF);

endpackage

// File: rtl/buffer_ptr_ctrl_ptr_counter.sv
// Free-running pointer with enable; natural binary rollover wraps the
// address and toggles the MSB wrap bit on the same edge.
module ptr_counter #(
  parameter int W = buffer_pkg::PTR_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] ptr
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     ptr <= '0;
    else if (en) ptr <= ptr + W'(1);
  end

endmodule

// File: rtl/buffer_ptr_ctrl.sv
// Read/write pointer control for a 2**BufferWidth entry buffer.
// Define BUFFER_PTR_CTRL_ERR_EN to enable sticky Overflow/Underflow flags.
module buffer_ptr_ctrl
  import buffer_pkg::*;
#(
  parameter int BufferWidth = BUFFER_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   Push,
  input  logic                   Pop,
  input  logic                   ErrClr,
  output logic [BufferWidth-1:0] W_Addr,
  output logic [BufferWidth-1:0] R_Addr,
  output logic                   W_En,
  output logic                   R_En,
  output logic                   Full,
  output logic                   Empty,
  output logic [BufferWidth:0]   Count,
  output logic                   Overflow,
  output logic                   Underflow
);

  localparam int PtrW = ptr_width(BufferWidth);

  logic [PtrW-1:0] wptr, rptr;
  logic            ovf_evt, unf_evt;

  ptr_counter #(.W(PtrW)) u_wptr (.clk(clk), .rst(rst), .en(W_En), .ptr(wptr));
  ptr_counter #(.W(PtrW)) u_rptr (.clk(clk), .rst(rst), .en(R_En), .ptr(rptr));

  assign W_Addr = wptr[BufferWidth-1:0];
  assign R_Addr = rptr[BufferWidth-1:0];
  assign Empty  = (wptr == rptr);
  assign Full   = (W_Addr == R_Addr) && (wptr[BufferWidth] != rptr[BufferWidth]);
  assign Count  = wptr - rptr;

  // A pop frees a slot in the same cycle, so a push against Full still lands.
  assign W_En = Push & (~Full | Pop);
  assign R_En = Pop & ~Empty;

  assign ovf_evt = Push & ~W_En;
  assign unf_evt = Pop & ~R_En;

`ifdef BUFFER_PTR_CTRL_ERR_EN
  // A fresh event outranks a clear in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
    end else begin
      if (ovf_evt)     Overflow <= 1'b1;
      else if (ErrClr) Overflow <= 1'b0;
      if (unf_evt)     Underflow <= 1'b1;
      else if (ErrClr) Underflow <= 1'b0;
    end
  end
`else
  logic unused_err;
  assign unused_err = ErrClr ^ ovf_evt ^ unf_evt;
  assign Overflow   = 1'b0;
  assign Underflow  = 1'b0;
`endif

endmodule

// File: tb/tb_buffer_ptr_ctrl.sv
// Directed bench for buffer_ptr_ctrl at BufferWidth=2 (depth 4).
`timescale 1ns/1ps
module tb_buffer_ptr_ctrl;

`ifdef BUFFER_PTR_CTRL_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       Push = 1'b0, Pop = 1'b0, ErrClr = 1'b0;
  logic [1:0] W_Addr, R_Addr;
  logic       W_En, R_En, Full, Empty, Overflow, Underflow;
  logic [2:0] Count;

  int nvec = 0;
  int nmis = 0;

  buffer_ptr_ctrl #(.BufferWidth(2)) dut (
    .clk(clk), .rst(rst), .Push(Push), .Pop(Pop), .ErrClr(ErrClr),
    .W_Addr(W_Addr), .R_Addr(R_Addr), .W_En(W_En), .R_En(R_En),
    .Full(Full), .Empty(Empty), .Count(Count),
    .Overflow(Overflow), .Underflow(Underflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    step(); step();
    nvec++;
    if ({W_Addr, R_Addr, Count, Empty, Full, Overflow, Underflow} !== {2'd0, 2'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      nmis++;
      $display("FAIL reset: W_Addr=%0d R_Addr=%0d Count=%0d Empty=%b Full=%b Ovf=%b Unf=%b, want 0 0 0 1 0 0 0",
               W_Addr, R_Addr, Count, Empty, Full, Overflow, Underflow);
    end
    rst = 1'b0;
  endtask

  task automatic test_fill();
    Push = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      nvec++;
      if (W_En !== 1'b1) begin nmis++; $display("FAIL fill_wen%0d: got %b want 1", i, W_En); end
      step();
      nvec++;
      if (Count !== 3'(i) || W_Addr !== 2'(i)) begin
        nmis++; $display("FAIL fill_cnt%0d: Count=%0d W_Addr=%0d want %0d %0d", i, Count, W_Addr, i, i % 4);
      end
    end
    nvec++;
    if (Full !== 1'b1 || Empty !== 1'b0 || dut.wptr[2] !== 1'b1) begin
      nmis++; $display("FAIL fill_full: Full=%b Empty=%b wrap=%b want 1 0 1", Full, Empty, dut.wptr[2]);
    end
    #1;
    nvec++;
    if (W_En !== 1'b0) begin nmis++; $display("FAIL fill_5th_wen: got %b want 0", W_En); end
    step();
    Push = 1'b0;
    nvec++;
    if (Overflow !== ERR_EN || W_Addr !== 2'd0 || Count !== 3'd4) begin
      nmis++; $display("FAIL fill_ovf: Ovf=%b W_Addr=%0d Count=%0d want %b 0 4", Overflow, W_Addr, Count, ERR_EN);
    end
  endtask

  task automatic test_drain();
    Pop = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      nvec++;
      if (R_En !== 1'b1) begin nmis++; $display("FAIL drain_ren%0d: got %b want 1", i, R_En); end
      step();
      nvec++;
      if (Count !== 3'(4 - i) || R_Addr !== 2'(i)) begin
        nmis++; $display("FAIL drain_cnt%0d: Count=%0d R_Addr=%0d want %0d %0d", i, Count, R_Addr, 4 - i, i % 4);
      end
    end
    nvec++;
    if (Empty !== 1'b1 || Full !== 1'b0 || R_Addr !== 2'd0) begin
      nmis++; $display("FAIL drain_empty: Empty=%b Full=%b R_Addr=%0d want 1 0 0", Empty, Full, R_Addr);
    end
    #1;
    nvec++;
    if (R_En !== 1'b0) begin nmis++; $display("FAIL drain_extra_ren: got %b want 0", R_En); end
    step();
    nvec++;
    if (Underflow !== ERR_EN || Overflow !== ERR_EN || R_Addr !== 2'd0) begin
      nmis++; $display("FAIL drain_unf: Unf=%b Ovf=%b R_Addr=%0d want %b %b 0", Underflow, Overflow, R_Addr, ERR_EN, ERR_EN);
    end
    // refused pop together with clear: underflow must stick, overflow clears
    ErrClr = 1'b1;
    step();
    nvec++;
    if (Underflow !== ERR_EN || Overflow !== 1'b0) begin
      nmis++; $display("FAIL clr_vs_evt: Unf=%b Ovf=%b want %b 0", Underflow, Overflow, ERR_EN);
    end
    Pop = 1'b0;
    step();
    ErrClr = 1'b0;
    nvec++;
    if (Underflow !== 1'b0 || Overflow !== 1'b0) begin
      nmis++; $display("FAIL errclr: Unf=%b Ovf=%b want 0 0", Underflow, Overflow);
    end
  endtask

  task automatic test_simultaneous();
    Push = 1'b1;
    repeat (4) step();
    Push = 1'b0;
    nvec++;
    if (Full !== 1'b1 || W_Addr !== 2'd0 || R_Addr !== 2'd0) begin
      nmis++; $display("FAIL sim_prefill: Full=%b W_Addr=%0d R_Addr=%0d want 1 0 0", Full, W_Addr, R_Addr);
    end
    Push = 1'b1; Pop = 1'b1;
    #1;
    nvec++;
    if ({W_En, R_En} !== 2'b11) begin nmis++; $display("FAIL sim_full_en: W_En,R_En=%b want 11", {W_En, R_En}); end
    step();
    Push = 1'b0; Pop = 1'b0;
    nvec++;
    if (Count !== 3'd4 || Full !== 1'b1 || W_Addr !== 2'd1 || R_Addr !== 2'd1) begin
      nmis++; $display("FAIL sim_full: Count=%0d Full=%b W_Addr=%0d R_Addr=%0d want 4 1 1 1", Count, Full, W_Addr, R_Addr);
    end
    Pop = 1'b1;
    repeat (4) step();
    Pop = 1'b0;
    Push = 1'b1; Pop = 1'b1;
    #1;
    nvec++;
    if ({W_En, R_En} !== 2'b10) begin nmis++; $display("FAIL sim_empty_en: W_En,R_En=%b want 10", {W_En, R_En}); end
    step();
    Push = 1'b0; Pop = 1'b0;
    nvec++;
    if (Count !== 3'd1 || R_Addr !== 2'd1 || W_Addr !== 2'd2 || Underflow !== ERR_EN) begin
      nmis++; $display("FAIL sim_empty: Count=%0d R_Addr=%0d W_Addr=%0d Unf=%b want 1 1 2 %b",
                       Count, R_Addr, W_Addr, Underflow, ERR_EN);
    end
    ErrClr = 1'b1;
    step();
    ErrClr = 1'b0;
  endtask

  task automatic test_wrap();
    logic [1:0] er, ew;
    Push = 1'b1;
    step();
    er = 2'd1; ew = 2'd3;
    Pop = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      er = er + 2'd1; ew = ew + 2'd1;
      nvec++;
      if (Count !== 3'd2 || Full !== 1'b0 || Empty !== 1'b0 || R_Addr !== er || W_Addr !== ew) begin
        nmis++; $display("FAIL wrap%0d: Count=%0d Full=%b Empty=%b R=%0d W=%0d want 2 0 0 %0d %0d",
                         i, Count, Full, Empty, R_Addr, W_Addr, er, ew);
      end
    end
    Push = 1'b0; Pop = 1'b0;
  endtask

  task automatic test_async_rst();
    Push = 1'b1;
    step();
    Push = 1'b0;
    nvec++;
    if (Count !== 3'd3) begin nmis++; $display("FAIL arst_pre: Count=%0d want 3", Count); end
    Push = 1'b1;
    #2 rst = 1'b1;
    #1;
    nvec++;
    if ({W_Addr, R_Addr, Count, Empty, Full, Overflow, Underflow} !== {2'd0, 2'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      nmis++; $display("FAIL arst_async: W=%0d R=%0d Count=%0d Empty=%b Full=%b want 0 0 0 1 0",
                       W_Addr, R_Addr, Count, Empty, Full);
    end
    step();
    nvec++;
    if (Count !== 3'd0) begin nmis++; $display("FAIL arst_hold: Count=%0d want 0", Count); end
    rst = 1'b0;
    step();
    Push = 1'b0;
    nvec++;
    if (Count !== 3'd1 || W_Addr !== 2'd1) begin
      nmis++; $display("FAIL arst_resume: Count=%0d W_Addr=%0d want 1 1", Count, W_Addr);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_simultaneous();
    test_wrap();
    test_async_rst();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not finish, want finish before 20000ns");
    $fatal(1);
  end

endmodule
